jk_modn_counter: RTL and testbench

- Synchronous modulo-N up/down counter whose state register is a bank of JK flip-flops.
- The block is the J/K excitation stage that feeds those flip-flops: per-bit next-state logic maps count/load/direction requests onto JK modes (hold/set/reset/toggle).
- Sits directly upstream of, and encapsulates, the lab's JK storage cells.
- Used as the counting datapath for later lab sequencers (timers, dividers).

---
 rtl/jk_pkg.sv | 26 ++
 rtl/jk_cell.sv | 31 +++
 rtl/jk_modn_counter.sv | 97 +++++++++
 tb/tb_jk_modn_counter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared definitions for the JK counter slice: the four JK excitation modes
// and a helper that turns a mode into the {J,K} pin pair.
package jk_pkg;

    // Mode encoding is chosen so that the 2-bit value already reads as {J,K}.
    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_mode_e;

    // Map an excitation mode onto the {J,K} inputs of a JK flip-flop.
    function automatic logic [1:0] jk_mode_to_jk(input jk_mode_e mode);
        logic [1:0] w_jk;
        case (mode)
            JK_HOLD:   w_jk = 2'b00;
            JK_RESET:  w_jk = 2'b01;
            JK_SET:    w_jk = 2'b10;
            JK_TOGGLE: w_jk = 2'b11;
            default:   w_jk = 2'b00;
        endcase
        return w_jk;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop storage cell with asynchronous active-low clear.
// Qbar is always the complement of the stored bit, never driven on its own.
module jk_cell (
    input  logic clk,
    input  logic R,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic Qbar
);

    logic r_q;

    // JK storage: hold / reset / set / toggle on the rising edge, cleared by R=0.
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            r_q <= 1'b0;
        end else begin
            case ({J, K})
                2'b00:   r_q <= r_q;
                2'b01:   r_q <= 1'b0;
                2'b10:   r_q <= 1'b1;
                default: r_q <= ~r_q;
            endcase
        end
    end

    assign Q    = r_q;
    assign Qbar = ~r_q;

endmodule

// File: rtl/jk_modn_counter.sv
// Modulo-MODULUS up/down counter built from a bank of jk_cell flip-flops.
// This module holds only the per-bit J/K excitation logic; storage is in jk_cell.
// Optional macro JK_COUNTER_SAT_EN: when defined, the counter saturates at
// MODULUS-1 (up) and 0 (down) instead of wrapping.
module jk_modn_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             R,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             tc
);

    localparam int unsigned     LP_MAX_INT = MODULUS - 1;
    localparam logic [WIDTH-1:0] LP_MAX    = LP_MAX_INT[WIDTH-1:0];

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qbar;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    jk_mode_e         w_mode [WIDTH];
    logic             w_at_max;
    logic             w_at_zero;

    // ">=" rather than "==" so an out-of-range loaded value also takes the wrap path.
    assign w_at_max  = (w_q >= LP_MAX);
    assign w_at_zero = (w_q == '0);

    // Per-bit excitation: choose a JK mode for each bit from load/en/up and the count.
    always_comb begin
        logic w_low_ones;
        logic w_low_zeros;
        w_low_ones  = 1'b1;
        w_low_zeros = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            w_mode[i] = JK_HOLD;
            if (load) begin
                w_mode[i] = D[i] ? JK_SET : JK_RESET;
            end else if (en) begin
                if (up) begin
                    if (!w_at_max) begin
                        w_mode[i] = w_low_ones ? JK_TOGGLE : JK_HOLD;
                    end else begin
`ifdef JK_COUNTER_SAT_EN
                        // Park at MODULUS-1; bits already matching simply hold.
                        w_mode[i] = (w_q[i] == LP_MAX[i]) ? JK_HOLD
                                  : (LP_MAX[i] ? JK_SET : JK_RESET);
`else
                        w_mode[i] = w_q[i] ? JK_RESET : JK_HOLD;
`endif
                    end
                end else begin
                    if (!w_at_zero) begin
                        w_mode[i] = w_low_zeros ? JK_TOGGLE : JK_HOLD;
                    end else begin
`ifdef JK_COUNTER_SAT_EN
                        w_mode[i] = JK_HOLD;
`else
                        w_mode[i] = LP_MAX[i] ? JK_SET : JK_RESET;
`endif
                    end
                end
            end
            w_low_ones  = w_low_ones & w_q[i];
            w_low_zeros = w_low_zeros & ~w_q[i];
        end
    end

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_cell
            assign {w_j[g], w_k[g]} = jk_mode_to_jk(w_mode[g]);

            jk_cell u_cell (
                .clk  (clk),
                .R    (R),
                .J    (w_j[g]),
                .K    (w_k[g]),
                .Q    (w_q[g]),
                .Qbar (w_qbar[g])
            );
        end
    endgenerate

    assign Q    = w_q;
    assign Qbar = w_qbar;
    assign tc   = en & ~load & ((up & w_at_max) | (~up & w_at_zero));

endmodule

// File: tb/tb_jk_modn_counter.sv
// Bench for jk_modn_counter: a MODULUS=10 and a MODULUS=16 instance share inputs.
// Directed table, hand-written corner sequences, then random stimulus against an
// arithmetic reference model.
module tb_jk_modn_counter;

`ifdef JK_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       R;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] D;
    logic [3:0] q10, qbar10, q16, qbar16;
    logic       tc10, tc16;

    int n_tests;
    int n_fail;
    int m10;
    int m16;

    jk_modn_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
        .clk(clk), .R(R), .en(en), .up(up), .load(load), .D(D),
        .Q(q10), .Qbar(qbar10), .tc(tc10)
    );

    jk_modn_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clk(clk), .R(R), .en(en), .up(up), .load(load), .D(D),
        .Q(q16), .Qbar(qbar16), .tc(tc16)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: next count from the behavioural rules, modulo md
    function automatic int model_next(input int q, input int md, input bit l,
                                      input bit e, input bit u, input int d);
        if (l) return d;
        if (!e) return q;
        if (u) begin
            if (q >= md - 1) return SAT ? md - 1 : 0;
            return q + 1;
        end
        if (q == 0) return SAT ? 0 : md - 1;
        return q - 1;
    endfunction

    function automatic bit model_tc(input int q, input int md, input bit l,
                                    input bit e, input bit u);
        return e && !l && ((u && q >= md - 1) || (!u && q == 0));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_q_both(input string tag);
        chk({tag, " q10"},    int'(q10),    m10);
        chk({tag, " qbar10"}, int'(qbar10), (~m10) & 15);
        chk({tag, " q16"},    int'(q16),    m16);
        chk({tag, " qbar16"}, int'(qbar16), (~m16) & 15);
    endtask

    // driver: apply inputs, check tc before the edge, advance one edge, check Q
    task automatic cycle(input bit l, input bit e, input bit u, input logic [3:0] d,
                         input string tag);
        load = l; en = e; up = u; D = d;
        #2;
        chk({tag, " tc10"}, int'(tc10), int'(model_tc(m10, 10, l, e, u)));
        chk({tag, " tc16"}, int'(tc16), int'(model_tc(m16, 16, l, e, u)));
        @(posedge clk);
        m10 = model_next(m10, 10, l, e, u, int'(d));
        m16 = model_next(m16, 16, l, e, u, int'(d));
        #1;
        chk_q_both(tag);
    endtask

    typedef struct {
        bit         l;
        bit         e;
        bit         u;
        logic [3:0] d;
        int         exp_tc10;
        int         exp_q10;
    } vec_t;

    vec_t vecs[$];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m10 = 0;
        m16 = 0;

        // reset held with load/en active and clock running
        R = 1'b0; en = 1'b1; up = 1'b1; load = 1'b1; D = 4'hA;
        repeat (3) @(posedge clk);
        #1;
        chk("rst q10", int'(q10), 0);
        chk("rst qbar10", int'(qbar10), 15);
        chk("rst tc10 load", int'(tc10), 0);
        chk("rst q16", int'(q16), 0);
        load = 1'b0; up = 1'b0;
        #1;
        chk("rst tc10 down", int'(tc10), 1);
        @(negedge clk);
        R = 1'b1;

        // directed table for the MODULUS=10 instance (MODULUS=16 follows the model)
        vecs.push_back('{1, 0, 0, 4'd8, 0, 8});
        vecs.push_back('{0, 1, 1, 4'd0, 0, 9});
        vecs.push_back('{0, 1, 1, 4'd0, 1, 0});
        vecs.push_back('{0, 1, 1, 4'd0, 0, 1});
        vecs.push_back('{1, 0, 0, 4'd1, 0, 1});
        vecs.push_back('{0, 1, 0, 4'd0, 0, 0});
        vecs.push_back('{0, 1, 0, 4'd0, 1, 9});
        vecs.push_back('{0, 1, 0, 4'd0, 0, 8});
        vecs.push_back('{1, 0, 0, 4'd3, 0, 3});
        vecs.push_back('{1, 1, 1, 4'd7, 0, 7});
        for (int i = 0; i < 5; i++) vecs.push_back('{0, 0, 1, 4'd0, 0, 7});

        foreach (vecs[i]) begin
            load = vecs[i].l; en = vecs[i].e; up = vecs[i].u; D = vecs[i].d;
            #2;
            chk($sformatf("vec%0d tc10", i), int'(tc10), vecs[i].exp_tc10);
            chk($sformatf("vec%0d tc16", i), int'(tc16),
                int'(model_tc(m16, 16, vecs[i].l, vecs[i].e, vecs[i].u)));
            @(posedge clk);
            m10 = vecs[i].exp_q10;
            m16 = model_next(m16, 16, vecs[i].l, vecs[i].e, vecs[i].u, int'(vecs[i].d));
            #1;
            chk_q_both($sformatf("vec%0d", i));
        end

        // asynchronous reset mid-count: Q clears before any clock edge
        cycle(1, 0, 1, 4'd5, "pre-arst");
        #3;
        R = 1'b0;
        #1;
        m10 = 0;
        m16 = 0;
        chk_q_both("arst");
        @(negedge clk);
        R = 1'b1;

        // out-of-range load then count up / down
        cycle(1, 0, 1, 4'd12, "oor load up");
        cycle(0, 1, 1, 4'd0, "oor up");
        chk("oor up q10 direct", int'(q10), SAT ? 9 : 0);
        cycle(1, 0, 0, 4'd12, "oor load dn");
        cycle(0, 1, 0, 4'd0, "oor dn");
        chk("oor dn q10 direct", int'(q10), 11);

        // top-of-range behaviour on the full-width instance
        cycle(1, 0, 1, 4'd15, "top load");
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 4'd0, "top up");
        cycle(1, 0, 0, 4'd0, "bot load");
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 4'd0, "bot dn");

        // randomized stimulus against the model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
